// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy count,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module param_sync_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 512,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter bit FWFT      = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_rd_en,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic                       o_underflow,
  input  logic                       i_clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W:0]   LP_DEPTH     = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   LP_AF        = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0]   LP_AE        = AE_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0]   LP_LVL_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LP_LVL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LP_PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LP_PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] LP_DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wa;
  logic              w_ra;
  logic [ADDR_W:0]   w_level_nxt;

  // Status flags, accept strobes and next occupancy, all from the level register.
  always_comb begin
    w_full  = (r_level == LP_DEPTH);
    w_empty = (r_level == LP_LVL_ZERO);
    w_wa    = i_wr_en & ~w_full;
    w_ra    = i_rd_en & ~w_empty;
    case ({w_wa, w_ra})
      2'b10:   w_level_nxt = r_level + LP_LVL_ONE;
      2'b01:   w_level_nxt = r_level - LP_LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wa) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= LP_PTR_ZERO;
      r_rd_ptr <= LP_PTR_ZERO;
      r_level  <= LP_LVL_ZERO;
    end else begin
      if (w_wa) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_ra) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      r_level <= w_level_nxt;
    end
  end

  // Sticky error flags: a new error in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (i_wr_en & w_full)  | (r_overflow  & ~i_clr_err);
      r_underflow <= (i_rd_en & w_empty) | (r_underflow & ~i_clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented combinationally; rd_en only pops it.
      always_comb begin
        o_rd_data  = r_mem[r_rd_ptr];
        o_rd_valid = ~w_empty;
      end
    end else begin : g_std
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      // Registered read port: one-cycle valid pulse, data holds between reads.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_rd_data  <= LP_DATA_ZERO;
          r_rd_valid <= 1'b0;
        end else if (w_ra) begin
          r_rd_data  <= r_mem[r_rd_ptr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      // Drive the read port from its registers.
      always_comb begin
        o_rd_data  = r_rd_data;
        o_rd_valid = r_rd_valid;
      end
    end
  endgenerate

  // Output mapping; threshold flags are plain compares of the level register.
  always_comb begin
    o_full         = w_full;
    o_empty        = w_empty;
    o_almost_full  = (r_level >= LP_AF);
    o_almost_empty = (r_level <= LP_AE);
    o_level        = r_level;
    o_overflow     = r_overflow;
    o_underflow    = r_underflow;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock synchronous FIFO, the successor to the fixed 32x512 user-area FIFO. Adds configurable data width and depth, full-capacity use of all DEPTH entries, programmable almost-full/almost-empty thresholds, an occupancy output, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between the Wishbone/user-logic producer and the downstream consumer inside the user project area.

## Interface
- DATA_W, 32, data word width in bits (>=1)
- DEPTH, 512, number of storage entries; power of two, >=4
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
- AF_THRESH, DEPTH-4, almost_full asserts when level >= AF_THRESH (1..DEPTH)
- AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read (pop) request
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data qualifier (see Operation)
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Write accepted (wa) = wr_en & ~full. Read accepted (ra) = rd_en & ~empty. Flags used are the current-cycle values; a full FIFO never accepts a write in the same cycle as a read, and an empty FIFO never accepts a read in the same cycle as a write.
- On wa: mem[wr_ptr] <= wr_data; wr_ptr += 1. On ra: rd_ptr += 1. Pointers are ADDR_W bits and wrap modulo DEPTH.
- level: +1 on wa&~ra, -1 on ra&~wa, unchanged on both or neither. Width is ADDR_W+1, so level reaches exactly DEPTH.
- full, empty, almost_full and almost_empty are combinational compares of the level register.
- Standard mode (FWFT=0): on ra, rd_data <= mem[rd_ptr] and rd_valid <= 1 for one cycle. Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr] whenever ~empty, and rd_valid = ~empty. rd_en acknowledges (pops) the presented word. rd_data is don't-care while empty.
- overflow set on wr_en&full. underflow set on rd_en&empty. Both cleared by clr_err. A set condition in the same cycle as clr_err wins (flag stays 1).
- Storage contents are not reset. Data order is strictly first-in, first-out.

## Timing
- Reset values: level=0, empty=1, full=0, almost_empty=1, almost_full=0 (with AF_THRESH>=1), rd_valid=0, rd_data=0 (standard mode), overflow=0, underflow=0. Pointers are 0.
- Reset asserted mid-operation discards all contents on that edge. Requests in the reset cycle are ignored and do not set error flags.
- Write-to-visible latency: a write accepted at edge N gives empty=0 and level+1 after edge N. In FWFT mode rd_data is valid in that same cycle.
- Standard read latency: rd_en accepted at edge N gives rd_data/rd_valid valid after edge N, for one cycle.
- Back-to-back: one write and one read may be accepted every cycle, giving sustained throughput of 1 word/cycle each way.
- Simultaneous wa&ra at partial occupancy: level unchanged and both pointers advance.
- Wrap-around: after DEPTH writes and DEPTH reads, both pointers return to 0 with no data corruption.

## Test plan
- Reset, then write 0x1..0x4 on consecutive cycles (FWFT=0) -> level 1,2,3,4. Four reads return 0x1..0x4, each with a one-cycle rd_valid pulse; level ends at 0 and empty=1.
- Fill to DEPTH=512 -> full=1, level=512, almost_full first asserts at level 508. Extra write of 0xDEAD -> overflow=1, level stays 512. Drain all 512 -> original data in order, 0xDEAD absent.
- Empty FIFO, rd_en & wr_en(0xA5) together -> write accepted, read rejected, underflow=1, level=1. Next-cycle read returns 0xA5. clr_err -> underflow=0.
- Full FIFO, rd_en & wr_en together -> read accepted, write rejected, overflow=1, level=511.
- FWFT=1: write 0x55 at edge N -> after edge N, rd_valid=1 and rd_data=0x55 with no rd_en. Pop -> empty=1, rd_valid=0.
- Stream 1500 words with simultaneous wr/rd at level 3 -> level holds 3, pointers wrap twice, all data correct. Assert reset mid-stream -> level=0, empty=1, flags at reset values next cycle.
